// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: DMEM geometry, default widths
// and the port-select encoding used for the round-robin 'last' register.
package mem_arbiter_pkg;

  localparam int DMEMADDRBITS = 13;
  localparam int DMEMWORDBITS = 2;

  localparam int DEF_DBITS = 32;
  localparam int DEF_AW    = DMEMADDRBITS - DMEMWORDBITS;
  localparam int DEF_CNTW  = 16;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, clear wins.
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            inc,
  output logic [CNTW-1:0] cnt
);

  // count register; clear is the block's synchronous reset
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNTW{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-cycle memory arbiter (CPU port 0, loader/DMA port 1).
//
// Handshake: a port raises pN_req with we/addr/wdata and holds them stable
// until it sees pN_gnt in the same cycle; the access completes in that grant
// cycle. Read data returns one cycle later on rdata, qualified by pN_rvalid.
// Grants are combinational, so a port can be granted every cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DBITS = DEF_DBITS,
  parameter int AW    = DEF_AW,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [AW-1:0]    p0_addr,
  input  logic [DBITS-1:0] p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [AW-1:0]    p1_addr,
  input  logic [DBITS-1:0] p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [DBITS-1:0] rdata,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata,
  input  logic             p1_lock,
  output logic [CNTW-1:0]  gnt_cnt0,
  output logic [CNTW-1:0]  gnt_cnt1
);

  port_e      last;      // port granted most recently
  logic       locked;    // port 1 owns the memory for a locked burst
  logic [1:0] rvalid_q;  // read issued last cycle, one bit per port

  // grant selection: single requester wins, ties go round-robin unless locked
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!reset) begin
      if (p0_req && p1_req) begin
        if (locked || (last == PORT_CPU)) begin
          p1_gnt = 1'b1;
        end else begin
          p0_gnt = 1'b1;
        end
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  // memory drive from the granted port, all zero when idle
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // arbitration history, lock tracking and read-return pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= PORT_DMA;
      locked   <= 1'b0;
      rvalid_q <= 2'b00;
    end else begin
      if (p0_gnt) begin
        last <= PORT_CPU;
      end else if (p1_gnt) begin
        last <= PORT_DMA;
      end
      if (!p1_lock || !p1_req) begin
        locked <= 1'b0;
      end else if (p1_gnt) begin
        locked <= 1'b1;
      end
      rvalid_q <= {p1_gnt & ~p1_we, p0_gnt & ~p0_we};
    end
  end

  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign rdata     = (|rvalid_q) ? mem_rdata : '0;

  sat_counter #(.CNTW(CNTW)) u_cnt0 (
    .clk   (clk),
    .clear (reset),
    .inc   (p0_gnt),
    .cnt   (gnt_cnt0)
  );

  sat_counter #(.CNTW(CNTW)) u_cnt1 (
    .clk   (clk),
    .clear (reset),
    .inc   (p1_gnt),
    .cnt   (gnt_cnt1)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a vector table of per-cycle requests with hand-derived
// grants, a behavioural 1-cycle-latency memory, and a read-return scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DBITS = 32;
  localparam int AW    = 11;
  localparam int CNTW  = 16;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [AW-1:0]    p0_addr, p1_addr;
  logic [DBITS-1:0] p0_wdata, p1_wdata;
  logic             p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we;
  logic [DBITS-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]    mem_addr;
  logic [CNTW-1:0]  gnt_cnt0, gnt_cnt1;

  // small-counter instance outputs
  logic             s_p0_gnt, s_p1_gnt, s_p0_rvalid, s_p1_rvalid, s_mem_we;
  logic [DBITS-1:0] s_rdata, s_mem_wdata;
  logic [AW-1:0]    s_mem_addr;
  logic [3:0]       s_cnt0, s_cnt1;

  mem_arbiter #(.DBITS(DBITS), .AW(AW), .CNTW(CNTW)) u_dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .p1_lock(p1_lock),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  mem_arbiter #(.DBITS(DBITS), .AW(AW), .CNTW(4)) u_dut_sat (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(s_p0_gnt), .p0_rvalid(s_p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(s_p1_gnt), .p1_rvalid(s_p1_rvalid),
    .rdata(s_rdata), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .p1_lock(p1_lock),
    .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1)
  );

  // ---------------- memory model (driven by the main DUT) ----------------
  logic [DBITS-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [DBITS:0]   exp_q[$];        // {port, read data}
  logic [DBITS-1:0] ref_mem [DEPTH]; // intended memory contents
  int exp_c0 = 0;
  int exp_c1 = 0;
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string            name;
    logic             rst;
    logic             r0, we0;
    logic [AW-1:0]    a0;
    logic [DBITS-1:0] d0;
    logic             r1, we1;
    logic [AW-1:0]    a1;
    logic [DBITS-1:0] d1;
    logic             lk;
    logic             eg0, eg1;
  } vec_t;

  function automatic vec_t mk(input string n, input bit rst,
                              input bit r0, input bit we0, input int a0, input logic [DBITS-1:0] d0,
                              input bit r1, input bit we1, input int a1, input logic [DBITS-1:0] d1,
                              input bit lk, input bit eg0, input bit eg1);
    vec_t v;
    v.name = n; v.rst = rst;
    v.r0 = r0; v.we0 = we0; v.a0 = AW'(a0); v.d0 = d0;
    v.r1 = r1; v.we1 = we1; v.a1 = AW'(a1); v.d1 = d1;
    v.lk = lk; v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  // ---------------- driver: one cycle per vector ----------------
  task automatic step(input vec_t v);
    logic [DBITS:0] e;
    @(posedge clk);
    #1;
    reset    = v.rst;
    p0_req   = v.r0;  p0_we = v.we0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req   = v.r1;  p1_we = v.we1; p1_addr = v.a1; p1_wdata = v.d1;
    p1_lock  = v.lk;
    @(negedge clk);
    // read return from the previous cycle
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({v.name, " p0_rvalid"}, 64'(p0_rvalid), 64'(!e[DBITS]));
      chk({v.name, " p1_rvalid"}, 64'(p1_rvalid), 64'(e[DBITS]));
      chk({v.name, " rdata"}, 64'(rdata), 64'(e[DBITS-1:0]));
    end else begin
      chk({v.name, " p0_rvalid"}, 64'(p0_rvalid), 64'(0));
      chk({v.name, " p1_rvalid"}, 64'(p1_rvalid), 64'(0));
      chk({v.name, " rdata"}, 64'(rdata), 64'(0));
    end
    // this cycle's grant and memory drive
    chk({v.name, " p0_gnt"}, 64'(p0_gnt), 64'(v.eg0));
    chk({v.name, " p1_gnt"}, 64'(p1_gnt), 64'(v.eg1));
    chk({v.name, " mem_we"}, 64'(mem_we),
        64'(v.eg0 ? v.we0 : (v.eg1 ? v.we1 : 1'b0)));
    chk({v.name, " mem_addr"}, 64'(mem_addr),
        64'(v.eg0 ? v.a0 : (v.eg1 ? v.a1 : '0)));
    chk({v.name, " mem_wdata"}, 64'(mem_wdata),
        64'(v.eg0 ? v.d0 : (v.eg1 ? v.d1 : '0)));
    chk({v.name, " gnt_cnt0"}, 64'(gnt_cnt0), 64'(exp_c0));
    chk({v.name, " gnt_cnt1"}, 64'(gnt_cnt1), 64'(exp_c1));
    // advance the model
    if (v.rst) begin
      exp_c0 = 0;
      exp_c1 = 0;
    end else begin
      if (v.eg0) begin
        exp_c0++;
        if (!v.we0) exp_q.push_back({1'b0, ref_mem[v.a0]});
        else        ref_mem[v.a0] = v.d0;
      end
      if (v.eg1) begin
        exp_c1++;
        if (!v.we1) exp_q.push_back({1'b1, ref_mem[v.a1]});
        else        ref_mem[v.a1] = v.d1;
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- test ----------------
  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    p1_lock = 0;
    repeat (2) @(posedge clk);

    //                  name          rst r0 we0 a0  d0              r1 we1 a1  d1            lk eg0 eg1
    vecs.push_back(mk("reset_state",  0,  0, 0,  0,  0,              0, 0,  0,  0,            0, 0,  0));
    vecs.push_back(mk("p1_wr5",       0,  0, 0,  0,  0,              1, 1,  5,  32'hDEADBEEF, 0, 0,  1));
    vecs.push_back(mk("p0_rd5",       0,  1, 0,  5,  0,              0, 0,  0,  0,            0, 1,  0));
    vecs.push_back(mk("rd5_data",     0,  0, 0,  0,  0,              0, 0,  0,  0,            0, 0,  0));
    vecs.push_back(mk("p0_wr7",       0,  1, 1,  7,  32'h123,        0, 0,  0,  0,            0, 1,  0));
    vecs.push_back(mk("p0_rd7",       0,  1, 0,  7,  0,              0, 0,  0,  0,            0, 1,  0));
    vecs.push_back(mk("p1_rd5",       0,  0, 0,  0,  0,              1, 0,  5,  0,            0, 0,  1));
    vecs.push_back(mk("p1_wr8",       0,  0, 0,  0,  0,              1, 1,  8,  32'hA5A50008, 0, 0,  1));
    vecs.push_back(mk("p0_rd8",       0,  1, 0,  8,  0,              0, 0,  0,  0,            0, 1,  0));
    vecs.push_back(mk("tie_a",        0,  1, 0,  7,  0,              1, 0,  8,  0,            0, 0,  1));
    vecs.push_back(mk("tie_b",        0,  1, 0,  7,  0,              1, 1,  9,  32'h99,       0, 1,  0));
    vecs.push_back(mk("tie_c",        0,  1, 1,  10, 32'h10,         1, 1,  9,  32'h99,       0, 0,  1));
    vecs.push_back(mk("p0_held",      0,  1, 1,  10, 32'h10,         0, 0,  0,  0,            0, 1,  0));
    vecs.push_back(mk("pre_rst_rd",   0,  1, 0,  9,  0,              0, 0,  0,  0,            0, 1,  0));
    vecs.push_back(mk("rst_on_rd",    1,  1, 0,  9,  0,              1, 0,  8,  0,            0, 0,  0));
    vecs.push_back(mk("post_rst",     0,  0, 0,  0,  0,              0, 0,  0,  0,            0, 0,  0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk($sformatf("rr_tie%0d", i), 0, 1, 0, 5, 0, 1, 0, 7, 0, 0,
                        (i % 2) == 0, (i % 2) == 1));
    vecs.push_back(mk("rr_idle",      0,  0, 0,  0,  0,              0, 0,  0,  0,            0, 0,  0));
    vecs.push_back(mk("pre_lock",     0,  1, 1,  32, 32'h2020,       0, 0,  0,  0,            0, 1,  0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk($sformatf("lock_b%0d", i), 0, 1, 0, 32, 0, 1, 1, 16 + i,
                        DBITS'(i + 1), 1, 0, 1));
    vecs.push_back(mk("lock_end",     0,  1, 0,  32, 0,              0, 0,  0,  0,            0, 1,  0));
    vecs.push_back(mk("lock_idle",    0,  0, 0,  0,  0,              0, 0,  0,  0,            0, 0,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
      if (vecs[i].name == "rr_idle") begin
        chk("rr gnt_cnt0", 64'(gnt_cnt0), 64'd3);
        chk("rr gnt_cnt1", 64'(gnt_cnt1), 64'd3);
      end
    end

    // locked burst landed in memory in order
    for (int i = 0; i < 4; i++)
      chk($sformatf("lock mem[%0h]", 16 + i), 64'(mem[16 + i]), 64'(i + 1));

    // saturation: 20 port-0 grants after reset on a 4-bit counter
    step(mk("sat_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++)
      step(mk($sformatf("sat_wr%0d", i), 0, 1, 1, 48, DBITS'(i), 0, 0, 0, 0, 0, 1, 0));
    step(mk("sat_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("sat gnt_cnt0 (CNTW=4)", 64'(s_cnt0), 64'd15);
    chk("sat gnt_cnt1 (CNTW=4)", 64'(s_cnt1), 64'd0);
    chk("sat gnt_cnt0 (CNTW=16)", 64'(gnt_cnt0), 64'd20);

    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DBITS, default 32, data word width.
REQ-002 Parameter AW, default 11, word-index width (DMEMADDRBITS - DMEMWORDBITS).
REQ-003 Parameter CNTW, default 16, width of the per-port grant counters.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports `clk` and `reset`.
REQ-005 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- p0_req  in  1  CPU port access request
- p0_we  in  1  CPU port write (1) / read (0)
- p0_addr  in  AW  CPU port word index
- p0_wdata  in  DBITS  CPU port write data
- p0_gnt  out  1  CPU port request accepted this cycle
- p0_rvalid  out  1  CPU port read data valid
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid: same as port 0, for the loader/DMA port
- rdata  out  DBITS  read data, shared by both ports, qualified by pN_rvalid
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory word index
- mem_wdata  out  DBITS  memory write data
- mem_rdata  in  DBITS  memory read data, valid one cycle after the address is presented
- p1_lock  in  1  port 1 holds the grant for consecutive beats
- gnt_cnt0, gnt_cnt1  out  CNTW  saturating grant counters

Function
REQ-006 Grant and memory-drive logic SHALL be combinational from the current requests and state; at most one of p0_gnt and p1_gnt SHALL be 1 in any cycle.
REQ-007 A requester SHALL hold req, we, addr and wdata stable until it sees gnt; the granted request SHALL complete in the grant cycle.
REQ-008 With only one port requesting, that port SHALL be granted in the same cycle.
REQ-009 With both ports requesting, the port not granted last SHALL win (round-robin); the `last` register SHALL update on every grant.
REQ-010 Exception to round-robin: while `locked` is set and p1_req=1, port 1 SHALL win.
REQ-011 `locked` SHALL be set on a port-1 grant with p1_lock=1, and cleared on any cycle with p1_lock=0 or p1_req=0.
REQ-012 mem_addr, mem_we and mem_wdata SHALL be driven from the granted port; mem_we SHALL be 1 only on a granted write.
REQ-013 With no grant, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-014 A granted read SHALL assert the matching pN_rvalid exactly one cycle after gnt, with rdata=mem_rdata.
REQ-015 A granted write SHALL produce no rvalid.
REQ-016 Back-to-back grants every cycle SHALL be supported, giving throughput of one access per cycle.
REQ-017 A read grant in cycle N and a write grant in cycle N+1 SHALL both complete: read data in N+1, write in N+1.
REQ-018 gnt_cnt0/gnt_cnt1 SHALL increment on each grant of their port and saturate at all-ones, with no wrap.
REQ-019 rdata SHALL be 0 when neither rvalid is asserted.

Reset
REQ-020 On reset, every output SHALL be 0: gnt, rvalid, mem_*, rdata, counters.
REQ-021 On reset, `last` SHALL be set to port 1, so port 0 wins the first tie.
REQ-022 On reset, `locked` SHALL be 0.
REQ-023 A read granted in the cycle reset asserts SHALL NOT produce rvalid.
REQ-024 Requests SHALL NOT be granted while reset=1.

Structure
REQ-025 Default widths and port-select encodings (PORT_CPU=0, PORT_DMA=1) SHALL live in a shared package/header alongside the existing DMEM constants.
REQ-026 One sub-module, sat_counter (parameterised CNTW, inc, clear), SHALL be instantiated twice for the grant counters.
REQ-027 The remaining state SHALL be flops for last, locked, rvalid_q[1:0]; there SHALL be no separate FSM module.

Verification
REQ-028 Port 0 alone reads addr 0x005, with mem holding 0xDEADBEEF -> p0_gnt the same cycle; p0_rvalid next cycle; rdata=0xDEADBEEF.
REQ-029 Both ports request continuously for 6 cycles after reset -> grants alternate p0,p1,p0,p1,p0,p1; gnt_cnt0=3, gnt_cnt1=3.
REQ-030 Port 1 locks 4 write beats (addr 0x010..0x013, data 1..4) while port 0 requests throughout -> 4 consecutive p1_gnt, then p0_gnt; mem holds 1..4.
REQ-031 Port 0 write 0x123 to addr 7, then next cycle port 0 reads addr 7 -> rvalid next cycle, rdata=0x123.
REQ-032 CNTW=4, 20 port-0 grants -> gnt_cnt0 stays at 15.
REQ-033 Reset asserted on the cycle of a read grant -> no rvalid the next cycle; all outputs 0; the first subsequent tie goes to port 0.
